// File: rtl/transpose_rd_cmd_gen_if.sv
// MCIF read-request channel used by the Transpose read-command generator.
// The master issues burst requests and receives the per-burst completion pulses.
interface transpose_rd_cmd_gen_if #(
    parameter int ADDR_W     = 32,
    parameter int LOG2_BURST = 4
);
    logic                         rd_req_vld;
    logic                         rd_req_rdy;
    logic [LOG2_BURST+ADDR_W-1:0] rd_req_pd;
    logic                         rd_burst_done;

    modport master (
        output rd_req_vld,
        output rd_req_pd,
        input  rd_req_rdy,
        input  rd_burst_done
    );

    modport slave (
        input  rd_req_vld,
        input  rd_req_pd,
        output rd_req_rdy,
        output rd_burst_done
    );
endinterface

// File: rtl/transpose_rd_cmd_gen.sv
// Walks channel slices x W bursts x H rows and issues MCIF burst reads,
// limited by a credit count of accepted-but-incomplete bursts.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_ISSUE | issuing requests, gated by outstanding credits
// S_DRAIN | final request accepted, waiting for remaining completions
module transpose_rd_cmd_gen #(
    parameter int ADDR_W     = 32,
    parameter int LOG2_BURST = 4,
    parameter int CH_DIV_W   = 8,
    parameter int H_W        = 12,
    parameter int W_W        = 12,
    parameter int BEAT_BYTES = 64,
    parameter int MAX_OUTST  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     surface_stride,
    input  logic [ADDR_W-1:0]     line_stride,
    input  logic [CH_DIV_W-1:0]   ch_div,
    input  logic [H_W-1:0]        h_in,
    input  logic [W_W-1:0]        w_in,
    transpose_rd_cmd_gen_if.master rd,
    output logic                  busy,
    output logic                  done
);

    localparam int                BURST  = 2 ** LOG2_BURST;
    localparam int                WB_W   = W_W - LOG2_BURST + 1;
    localparam int                OUT_W  = $clog2(MAX_OUTST + 1);
    localparam logic [ADDR_W-1:0] W_STEP = ADDR_W'(BURST * BEAT_BYTES);
    localparam logic [OUT_W-1:0]  OUT_MAX = OUT_W'(MAX_OUTST);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic                done_set;

    logic [CH_DIV_W-1:0] ch_cnt;
    logic [WB_W-1:0]     wb_cnt;
    logic [H_W-1:0]      h_cnt;
    logic [ADDR_W-1:0]   ch_off, w_off, h_off;
    logic [OUT_W-1:0]    outst, outst_nxt;

    logic [WB_W-1:0]     num_wb;
    logic                last_ch, last_wb, last_h, final_req;
    logic                dims_ok, accept, retire;
    logic [LOG2_BURST-1:0] cmd_len;
    logic [ADDR_W-1:0]     cmd_addr;

    assign num_wb    = WB_W'(({1'b0, w_in} + (W_W+1)'(BURST - 1)) >> LOG2_BURST);
    assign last_ch   = (ch_cnt == ch_div - CH_DIV_W'(1));
    assign last_wb   = (wb_cnt == num_wb - WB_W'(1));
    assign last_h    = (h_cnt == h_in - H_W'(1));
    assign final_req = last_ch && last_wb && last_h;
    assign dims_ok   = (ch_div != '0) && (h_in != '0) && (w_in != '0);

    // Only the last burst of a row can be short; an exact multiple yields a full burst.
    assign cmd_len  = last_wb ? LOG2_BURST'(w_in - W_W'(1)) : '1;
    assign cmd_addr = base_addr + ch_off + w_off + h_off;

    assign rd.rd_req_vld = (state == S_ISSUE) && (outst < OUT_MAX);
    assign rd.rd_req_pd  = {cmd_len, cmd_addr};
    assign accept        = rd.rd_req_vld && rd.rd_req_rdy;
    assign retire        = rd.rd_burst_done && (outst != '0);
    assign busy          = (state != S_IDLE);

    always_comb begin
        outst_nxt = outst;
        case ({accept, retire})
            2'b10:   outst_nxt = outst + OUT_W'(1);
            2'b01:   outst_nxt = outst - OUT_W'(1);
            default: outst_nxt = outst;
        endcase
    end

    always_comb begin
        state_nxt = state;
        done_set  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (dims_ok) state_nxt = S_ISSUE;
                    else         done_set  = 1'b1;
                end
            end
            S_ISSUE: begin
                if (accept && final_req) begin
                    if (outst_nxt == '0) begin
                        state_nxt = S_IDLE;
                        done_set  = 1'b1;
                    end else begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (outst_nxt == '0) begin
                    state_nxt = S_IDLE;
                    done_set  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            done  <= 1'b0;
            outst <= '0;
        end else begin
            state <= state_nxt;
            done  <= done_set;
            outst <= outst_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt <= '0;
            wb_cnt <= '0;
            h_cnt  <= '0;
            ch_off <= '0;
            w_off  <= '0;
            h_off  <= '0;
        end else if ((state == S_IDLE) && start) begin
            ch_cnt <= '0;
            wb_cnt <= '0;
            h_cnt  <= '0;
            ch_off <= '0;
            w_off  <= '0;
            h_off  <= '0;
        end else if (accept) begin
            if (!last_ch) begin
                ch_cnt <= ch_cnt + CH_DIV_W'(1);
                ch_off <= ch_off + surface_stride;
            end else begin
                ch_cnt <= '0;
                ch_off <= '0;
                if (!last_wb) begin
                    wb_cnt <= wb_cnt + WB_W'(1);
                    w_off  <= w_off + W_STEP;
                end else begin
                    wb_cnt <= '0;
                    w_off  <= '0;
                    if (!last_h) begin
                        h_cnt <= h_cnt + H_W'(1);
                        h_off <= h_off + line_stride;
                    end else begin
                        h_cnt <= '0;
                        h_off <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: doc/transpose_rd_cmd_gen.md
Name: transpose_rd_cmd_gen

Overview:
Parametrised next-generation read-command generator for the Transpose engine. It walks a 3-D feature map (channel slices × W bursts × H rows) and issues burst read requests to the MCIF. Over the previous generation it adds:
- an H-row loop using line_stride;
- full-width address arithmetic, with no 16-bit truncation;
- a configurable burst length;
- outstanding-burst credit flow control;
- an explicit IDLE/ISSUE/DRAIN state machine with a done pulse.

It sits between the Transpose CSR block and the MCIF read port.

Parameters:
ADDR_W, 32, address width of base, strides and command address
LOG2_BURST, 4, log2 of maximum burst length in beats (AXI_BURST_LEN = 2**LOG2_BURST)
CH_DIV_W, 8, width of channel-slice count (CH/Tout)
H_W, 12, width of row count
W_W, 12, width of pixel (beat) count per row
BEAT_BYTES, 64, bytes per beat (Tout*MAX_DAT_DW/8)
MAX_OUTST, 8, maximum accepted-but-incomplete bursts (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle start pulse; sampled only in IDLE
base_addr  in  ADDR_W  tensor base byte address
surface_stride  in  ADDR_W  byte step between channel slices
line_stride  in  ADDR_W  byte step between rows
ch_div  in  CH_DIV_W  channel slices (CH/Tout)
h_in  in  H_W  rows
w_in  in  W_W  beats per row
rd_req_vld  out  1  request valid
rd_req_rdy  in  1  MCIF accepts request
rd_req_pd  out  LOG2_BURST+ADDR_W  {cmd_len, cmd_addr}; cmd_len = beats-1
rd_burst_done  in  1  one pulse per completed burst (last beat returned)
busy  out  1  high in ISSUE or DRAIN
done  out  1  one-cycle pulse at job end

Behaviour:
- Reset: state=IDLE; all counters and offsets 0; rd_req_vld=0; busy=0; done=0; outstanding=0.
- Configuration inputs must hold stable while busy=1. They are not registered.
- Loop order, innermost first: ch (0..ch_div-1), wb (0..ceil(w_in/BURST)-1), h (0..h_in-1).
- cmd_addr = base_addr + ch*surface_stride + h*line_stride + wb*BURST*BEAT_BYTES, modulo 2**ADDR_W.
  - Computed from incrementally accumulated offsets: ch_off, w_off, h_off, each ADDR_W wide.
  - No multipliers.
- cmd_len = (w_in-1) mod BURST on the last wb of a row, else BURST-1.
- Accept event: rd_req_vld & rd_req_rdy.
  - On accept, ch advances.
  - ch wrap advances wb, and ch_off returns to 0.
  - wb wrap advances h, and w_off returns to 0.
  - h wrap marks the final request.
- rd_req_vld = (state==ISSUE) & (outstanding < MAX_OUTST).
  - vld and pd are combinational from registered state.
  - Once vld is high, pd holds until accepted.
  - vld never deasserts without an accept unless reset occurs. Credit only drops on accept, so this holds.
- outstanding update per cycle: +1 on accept, -1 on rd_burst_done. Both in the same cycle means no change.
  - rd_burst_done with outstanding==0 is illegal; the counter saturates at 0.
- FSM:
  - IDLE -> ISSUE on start when ch_div, h_in and w_in are all non-zero.
  - IDLE -> IDLE on start when any dimension is zero; done pulses on the next cycle.
  - ISSUE -> DRAIN on accept of the final request.
  - DRAIN -> IDLE when the next outstanding value is 0; done=1 in the following cycle, registered.
  - If the final accept and the last completion make outstanding 0 in the same cycle, go ISSUE -> IDLE directly, with done in the next cycle.
- start while busy is ignored.
- Asynchronous reset mid-job aborts immediately to the reset state. No done is generated.
- Total requests = ch_div * h_in * ceil(w_in/BURST).

Test Plan:
- Basic job: base=0x1000, ss=0x4000, ls=0x800, ch_div=2, h_in=2, w_in=20, BURST=16, BEAT=64, rdy=1, rd_burst_done 3 cycles after each accept.
  - Required: 8 requests in the order (addr,len) = (0x1000,15) (0x5000,15) (0x1400,3) (0x5400,3) (0x1800,15) (0x5800,15) (0x1C00,3) (0x5C00,3).
  - done pulses once after the 8th completion.
- Credit stall: MAX_OUTST=2, no rd_burst_done pulses.
  - Required: exactly 2 accepts, then vld=0.
  - One rd_burst_done pulse -> exactly one more accept.
- Backpressure: rdy toggles randomly.
  - Required: pd stable while vld&!rdy.
  - Request sequence identical to the rdy=1 case.
- Exact multiple and wrap: w_in=32 gives lens 15,15 per row.
  - base=0xFFFF_F000, ls=0x1000, h_in=2 -> second row address 0x0000_0000 (modular wrap).
  - ch_div=1, h_in=1, w_in=1 -> single request (base, len 0).
- Zero dimension: start with h_in=0 -> no requests, busy stays 0, done pulses once.
  - start asserted mid-job -> ignored; request count unchanged.
- Reset mid-job: drop rst_n after 3 accepts.
  - Required: vld, busy, done and outstanding are 0 immediately.
  - A new start then replays from base_addr.
